// File: rtl/int_sched.sv
// -----------------------------------------------------------------------------
// int_sched -- single-level interrupt scheduler for the processor datapath.
//
// Synchronises NSRC rising-edge interrupt lines, latches them into a pending
// register, and picks the lowest-index pending source that is enabled by the
// mask. Taking an interrupt squashes the instruction in flight, pushes its
// address onto the return stack and forces the fixed vector into the PC.
// Routines do not nest. A RETI opcode pops the stack, and one guard cycle then
// guarantees an instruction of forward progress before the next interrupt.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   irq            external interrupt lines (bit 0 = highest priority)
//   mask_we        load mask register from mask_d
//   mask_d         new mask value (bit n = 1 enables source n)
//   opcode         opcode of the instruction currently executing
//   s_interrupcion select interrupt vector into the PC
//   push_int       push the current PC onto the return stack
//   pop_int        pop the return stack
//   s_pop_int      select the stack output into the PC
//   squash         cancel the side effects of the current instruction
//   irq_id         index of the most recently taken source
//   pending        pending-request register
//   in_service     high while an interrupt routine is executing
// -----------------------------------------------------------------------------
module int_sched #(
  parameter logic [5:0] RETI_OP = 6'b111110,
  parameter int         NSRC    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_d,
  input  logic [5:0]      opcode,
  output logic            s_interrupcion,
  output logic            push_int,
  output logic            pop_int,
  output logic            s_pop_int,
  output logic            squash,
  output logic [1:0]      irq_id,
  output logic [NSRC-1:0] pending,
  output logic            in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    SERVICE = 2'd2,
    GUARD   = 2'd3
  } state_t;

  state_t          state;
  logic [NSRC-1:0] s1, s2, s3;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] edge_det;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] clr;
  logic [1:0]      winner;
  logic            take;
  logic            entry;

  // Lowest set index wins; scanning downward lets the lowest index overwrite.
  function automatic logic [1:0] prio_sel(input logic [NSRC-1:0] r);
    logic [1:0] sel;
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (r[i]) sel = 2'(i);
    end
    return sel;
  endfunction

  // Stage boundary: s1 -> s2 -> s3 synchroniser; s2 & ~s3 is the rising edge.
  // With the chain cleared by reset, a line already high at release shows up
  // as an edge, and a line held high produces exactly one edge.
  assign edge_det = s2 & ~s3;
  assign req      = pending & mask;
  assign winner   = prio_sel(req);
  assign take     = (state == IDLE) && (req != '0);
  assign clr      = take ? (NSRC'(1) << winner) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1         <= '0;
      s2         <= '0;
      s3         <= '0;
      pending    <= '0;
      mask       <= '0;
      irq_id     <= '0;
      state      <= IDLE;
      entry      <= 1'b0;
      in_service <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
      // A new edge on the source being taken is kept: set wins over clear.
      pending <= (pending & ~clr) | edge_det;
      if (mask_we) mask <= mask_d;

      case (state)
        IDLE: begin
          if (take) begin
            state  <= ENTRY;
            irq_id <= winner;
            entry  <= 1'b1;
          end
        end
        ENTRY: begin
          state      <= SERVICE;
          entry      <= 1'b0;
          in_service <= 1'b1;
        end
        SERVICE: begin
          if (opcode == RETI_OP) begin
            state      <= GUARD;
            in_service <= 1'b0;
          end
        end
        GUARD: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          entry      <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

  // ENTRY outputs come from a flop that mirrors the state; the return path is
  // decoded from opcode so the pop happens in the same cycle as the RETI.
  assign s_interrupcion = entry;
  assign push_int       = entry;
  assign squash         = entry;
  assign pop_int        = (state == SERVICE) && (opcode == RETI_OP);
  assign s_pop_int      = pop_int;

endmodule

// File: doc/int_sched.md
INT_SCHED -- requirements
Module: int_sched

Interface
REQ-001 Parameter RETI_OP, default 6'b111110, opcode value that ends an interrupt service routine.
REQ-002 Parameter NSRC, default 4, number of interrupt sources; fixed at 4 in this revision.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-005 irq  input  4  external interrupt lines, asynchronous, rising-edge sensitive; bit 0 highest priority.
REQ-006 mask_we  input  1  1 loads mask register from mask_d on the next rising edge.
REQ-007 mask_d  input  4  new mask value; bit n = 1 enables source n.
REQ-008 opcode  input  6  opcode of the instruction currently being executed by the datapath.
REQ-009 s_interrupcion  output  1  selects the fixed interrupt vector into the PC.
REQ-010 push_int  output  1  pushes current PC onto the return stack; ORed with main-control push.
REQ-011 pop_int  output  1  pops the return stack; ORed with main-control pop.
REQ-012 s_pop_int  output  1  selects stack output into the PC; ORed with main-control s_pop.
REQ-013 squash  output  1  1 gates we3, wez, write_enable, we_es, push and pop of the main control for the current instruction.
REQ-014 irq_id  output  2  index of the source most recently taken.
REQ-015 pending  output  4  pending-request register, for status readback.
REQ-016 in_service  output  1  1 while an interrupt routine is executing.

Function
REQ-017 Each irq bit SHALL pass a 3-flop chain (s1, s2, s3); rising edge detected as s2 & ~s3.
REQ-018 A detected edge SHALL set pending[n]; pending[n] SHALL clear only when source n is taken; set wins over clear in the same cycle.
REQ-019 Masked sources SHALL stay pending and are taken once unmasked.
REQ-020 Mask register SHALL update on mask_we; the new value SHALL take effect for the arbitration in the following cycle.
REQ-021 FSM states SHALL be IDLE, ENTRY, SERVICE, GUARD.
REQ-022 IDLE -> ENTRY when (pending & mask) != 0; otherwise stay.
REQ-023 Arbitration SHALL be fixed priority: lowest index among (pending & mask), evaluated in IDLE; winner is latched into irq_id and its pending bit is cleared on the IDLE->ENTRY edge.
REQ-024 ENTRY SHALL last exactly one cycle, assert s_interrupcion, push_int and squash, then go to SERVICE.
REQ-025 The squashed instruction's address is the pushed return address; it re-executes after return.
REQ-026 SERVICE SHALL hold in_service = 1 and ignore new requests; they accumulate in pending (no nesting).
REQ-027 In SERVICE, opcode == RETI_OP SHALL assert pop_int and s_pop_int combinationally in that cycle and go to GUARD.
REQ-028 GUARD SHALL last one cycle with all control outputs 0, guaranteeing one instruction of forward progress; then go to IDLE.
REQ-029 RETI_OP seen in IDLE or GUARD SHALL be ignored by this block.
REQ-030 Latency: irq high at rising edge k -> pending set after edge k+2 -> ENTRY during the cycle after edge k+3.
REQ-031 Control outputs (s_interrupcion, push_int, squash) SHALL be Moore decodes of state; pop_int/s_pop_int are Mealy on opcode in SERVICE only.
REQ-032 A request held high continuously SHALL generate exactly one pending set.

Reset
REQ-033 reset = 0 SHALL asynchronously force state IDLE, pending = 0, mask = 4'b0000, irq_id = 0, sync flops = 0.
REQ-034 During reset all outputs SHALL be 0; reset asserted mid-ENTRY or mid-SERVICE aborts it with no further push or pop.
REQ-035 After reset release an irq line already high SHALL count as a rising edge.

Verification
REQ-036 mask = 4'b0001, irq[0] pulse rises at edge k -> s_interrupcion = push_int = squash = 1 for exactly one cycle after edge k+3, irq_id = 0, pending = 0.
REQ-037 mask = 4'b1111, irq[3] and irq[1] rise at the same edge -> source 1 taken first (irq_id = 1); after RETI and GUARD, source 3 taken (irq_id = 3).
REQ-038 mask = 4'b0000, irq[2] rises -> pending = 4'b0100, no ENTRY; mask_we with 4'b0100 -> ENTRY two cycles later, irq_id = 2.
REQ-039 In SERVICE, irq[0] rises -> no ENTRY until opcode = RETI_OP gives pop_int = s_pop_int = 1, one GUARD cycle, then ENTRY.
REQ-040 reset = 0 asynchronously during SERVICE -> in_service = 0 and pending = 0 immediately; irq held high across release -> one new ENTRY, not two.
